// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry and writeback requester IDs.
package cpu_pkg;

    localparam int AW     = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Writeback requester identity; also the encoding of the arbiter priority bit.
    typedef enum logic {
        WB_A = 1'b0,
        WB_M = 1'b1
    } wb_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The priority bit only moves on a conflict,
// so a lone requester never disturbs fairness for the next collision.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_m,
    output logic gnt_a,
    output logic gnt_m
);

    wb_id_e prio_q;
    wb_id_e prio_d;

    // Grant selection and next priority: after a conflict, favour the loser.
    always_comb begin
        gnt_a  = req_a && (!req_m || (prio_q == WB_A));
        gnt_m  = req_m && !gnt_a;
        prio_d = prio_q;
        if (req_a && req_m) begin
            prio_d = gnt_a ? WB_M : WB_A;
        end
    end

    // Priority register, cleared to favour A on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= WB_A;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler with RAW scoreboard. Merges the ALU (A)
// and memory (M) writeback pipes onto one write port and stalls decode while
// a source register still has writes in flight. No data forwarding.
module regfile_wb_scheduler #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int AW     = cpu_pkg::AW,
    parameter int CNT_W  = cpu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rs,
    input  logic [AW-1:0]     iss_rt,
    input  logic              iss_wen,
    input  logic [AW-1:0]     iss_dst,
    output logic              stall,
    input  logic              a_valid,
    input  logic [AW-1:0]     a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              m_valid,
    input  logic [AW-1:0]     m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic              a_ready,
    output logic              m_ready,
    output logic              rf_wen,
    output logic [AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int NREG = 1 << AW;
    localparam logic [AW-1:0]    R0       = AW'(cpu_pkg::REG_ZERO);
    localparam logic [CNT_W-1:0] CNT_FULL = '1;

    // Entry 0 exists only so any address indexes safely; it is held at zero.
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    logic gnt_a;
    logic gnt_m;
    logic busy_rs;
    logic busy_rt;
    logic dst_full;
    logic inc;
    logic dec;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_a (a_valid),
        .req_m (m_valid),
        .gnt_a (gnt_a),
        .gnt_m (gnt_m)
    );

    // Hazard check: sources still pending, or destination counter saturated.
    always_comb begin
        busy_rs  = (iss_rs != R0) && (cnt_q[iss_rs] != '0);
        busy_rt  = (iss_rt != R0) && (cnt_q[iss_rt] != '0);
        dst_full = iss_wen && (iss_dst != R0) && (cnt_q[iss_dst] == CNT_FULL);
        stall    = iss_valid && (busy_rs || busy_rt || dst_full);
        inc      = iss_valid && !stall && iss_wen && (iss_dst != R0);
    end

    // Write-port mux: winner drives the port; r0 writes are accepted but suppressed.
    always_comb begin
        a_ready  = gnt_a;
        m_ready  = gnt_m;
        rf_waddr = '0;
        rf_wdata = '0;
        if (gnt_a) begin
            rf_waddr = a_addr;
            rf_wdata = a_data;
        end else if (gnt_m) begin
            rf_waddr = m_addr;
            rf_wdata = m_data;
        end
        rf_wen = (gnt_a || gnt_m) && (rf_waddr != R0);
        dec    = rf_wen;
    end

    // Counter update: issue +1, writeback -1, both cancel; a stray writeback cannot underflow.
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            logic inc_hit;
            logic dec_hit;
            inc_hit  = inc && (iss_dst == AW'(r));
            dec_hit  = dec && (rf_waddr == AW'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (inc_hit && !dec_hit) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_hit && !inc_hit) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // Scoreboard registers; reset discards all in-flight tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed vector table, hand-written reset
// sequence, then constrained-random traffic against a counting reference model.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rs = '0, iss_rt = '0, iss_dst = '0;
    logic        iss_wen = 1'b0;
    logic        stall;
    logic        a_valid = 1'b0, m_valid = 1'b0;
    logic [4:0]  a_addr = '0, m_addr = '0;
    logic [31:0] a_data = '0, m_data = '0;
    logic        a_ready, m_ready, rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int errors = 0;
    int checks = 0;

    regfile_wb_scheduler dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
        .iss_wen(iss_wen), .iss_dst(iss_dst), .stall(stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data),
        .a_ready(a_ready), .m_ready(m_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        iv;
        logic [4:0]  rs, rt;
        logic        wen;
        logic [4:0]  dst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_stall, e_ar, e_mr, e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                       input logic wen, input logic [4:0] dst,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic es, input logic ear, input logic emr, input logic ewen,
                       input logic [4:0] ewa, input logic [31:0] ewd);
        vec_t v;
        v.name = nm; v.iv = iv; v.rs = rs; v.rt = rt; v.wen = wen; v.dst = dst;
        v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
        v.e_stall = es; v.e_ar = ear; v.e_mr = emr; v.e_wen = ewen;
        v.e_waddr = ewa; v.e_wdata = ewd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                         input logic wen, input logic [4:0] dst,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        iss_valid = iv; iss_rs = rs; iss_rt = rt; iss_wen = wen; iss_dst = dst;
        a_valid = av; a_addr = aa; a_data = ad;
        m_valid = mv; m_addr = ma; m_data = md;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic chk_all(input string nm, input logic es, input logic ear, input logic emr,
                           input logic ewen, input logic [4:0] ewa, input logic [31:0] ewd);
        chk({nm, ".stall"},    {31'd0, stall},    {31'd0, es});
        chk({nm, ".a_ready"},  {31'd0, a_ready},  {31'd0, ear});
        chk({nm, ".m_ready"},  {31'd0, m_ready},  {31'd0, emr});
        chk({nm, ".rf_wen"},   {31'd0, rf_wen},   {31'd0, ewen});
        chk({nm, ".rf_waddr"}, {27'd0, rf_waddr}, {27'd0, ewa});
        chk({nm, ".rf_wdata"}, rf_wdata, ewd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Reference model state: outstanding writes per register and the priority owner (0 = A).
    int mcnt[32];
    int mprio;

    function automatic int reserved(input int r, input logic av, input logic [4:0] aa,
                                    input logic mv, input logic [4:0] ma);
        int n = 0;
        if (av && aa == 5'(r)) n++;
        if (mv && ma == 5'(r)) n++;
        return n;
    endfunction

    initial begin
        // Directed sequence after reset: prio starts at A, all counters zero.
        //   name       iv rs rt wen dst  av aa ad            mv ma md            st ar mr we wa wd
        add("raw_iss",   1, 0, 0, 1, 5,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0);
        add("raw_stall", 1, 5, 0, 0, 0,   0, 0, 0,            0, 0, 0,            1, 0, 0, 0, 0, 0);
        add("raw_wb",    1, 5, 0, 0, 0,   1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 1, 0, 1, 5, 32'hDEADBEEF);
        add("raw_clear", 1, 5, 0, 0, 0,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0);
        add("rr_1_A",    0, 0, 0, 0, 0,   1, 1, 32'hA1,       1, 2, 32'hB1,       0, 1, 0, 1, 1, 32'hA1);
        add("rr_2_M",    0, 0, 0, 0, 0,   1, 3, 32'hA2,       1, 2, 32'hB1,       0, 0, 1, 1, 2, 32'hB1);
        add("rr_3_A",    0, 0, 0, 0, 0,   1, 3, 32'hA2,       1, 4, 32'hB2,       0, 1, 0, 1, 3, 32'hA2);
        add("rr_4_M",    0, 0, 0, 0, 0,   1, 6, 32'hA3,       1, 4, 32'hB2,       0, 0, 1, 1, 4, 32'hB2);
        add("no_uflow",  1, 1, 2, 0, 0,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0);
        add("r7_iss1",   1, 0, 0, 1, 7,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0);
        add("r7_iss2",   1, 0, 0, 1, 7,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0);
        add("r7_iss3",   1, 0, 0, 1, 7,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0);
        add("r7_full",   1, 0, 0, 1, 7,   0, 0, 0,            0, 0, 0,            1, 0, 0, 0, 0, 0);
        add("r7_wb",     1, 0, 0, 1, 7,   0, 0, 0,            1, 7, 32'h77,       1, 0, 1, 1, 7, 32'h77);
        add("r7_iss4",   1, 0, 0, 1, 7,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0);
        add("r9_iss",    1, 0, 0, 1, 9,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0);
        add("r9_same",   1, 0, 0, 1, 9,   1, 9, 32'h99,       0, 0, 0,            0, 1, 0, 1, 9, 32'h99);
        add("r9_busy",   1, 9, 0, 0, 0,   0, 0, 0,            0, 0, 0,            1, 0, 0, 0, 0, 0);
        add("r9_wb",     1, 0, 9, 0, 0,   1, 9, 32'h9,        0, 0, 0,            1, 1, 0, 1, 9, 32'h9);
        add("r9_free",   1, 0, 9, 0, 0,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0);
        add("r0_wb_a",   1, 0, 0, 0, 0,   1, 0, 32'h12345678, 0, 0, 0,            0, 1, 0, 0, 0, 32'h12345678);
        add("r0_wb_m",   1, 0, 0, 1, 0,   0, 0, 0,            1, 0, 32'h55,       0, 0, 1, 0, 0, 32'h55);
        add("r7_still",  1, 7, 0, 0, 0,   0, 0, 0,            0, 0, 0,            1, 0, 0, 0, 0, 0);

        do_reset();
        chk_all("reset_idle", 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].rs, vecs[i].rt, vecs[i].wen, vecs[i].dst,
                  vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md);
            #1;
            chk_all(vecs[i].name, vecs[i].e_stall, vecs[i].e_ar, vecs[i].e_mr,
                    vecs[i].e_wen, vecs[i].e_waddr, vecs[i].e_wdata);
            tick();
        end

        // Mid-operation reset: build cnt[3]=2 and prio=M, then reset asynchronously.
        drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0, 32'hA0, 1, 0, 32'hB0);
        #1; chk_all("pre_rst_conflict", 0, 1, 0, 0, 0, 32'hA0);
        tick();
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("pre_rst_r3_busy", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1; chk("in_rst_stall", {31'd0, stall}, 32'd0);
        chk("in_rst_wen", {31'd0, rf_wen}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        drive(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("post_rst_r3", {31'd0, stall}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 32'hA5, 1, 0, 32'hB5);
        #1; chk_all("post_rst_prio", 0, 1, 0, 0, 0, 32'hA5);
        tick();

        // Random traffic against the reference model.
        do_reset();
        foreach (mcnt[r]) mcnt[r] = 0;
        mprio = 0;
        begin
            logic        av = 0, mv = 0;
            logic [4:0]  aa = 0, ma = 0;
            logic [31:0] ad = 0, md = 0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                logic       iv, wen, es, ga, gm, ewen;
                logic [4:0] rs, rt, dst, ewa;
                logic [31:0] ewd;
                int cand[$];
                if (!av && ($urandom % 2 == 0)) begin
                    cand.delete();
                    for (int r = 1; r < 32; r++)
                        if (mcnt[r] - reserved(r, av, aa, mv, ma) > 0) cand.push_back(r);
                    aa = (cand.size() == 0 || $urandom % 5 == 0) ? 5'd0
                         : 5'(cand[$urandom_range(cand.size() - 1, 0)]);
                    ad = $urandom; av = 1;
                end
                if (!mv && ($urandom % 2 == 0)) begin
                    cand.delete();
                    for (int r = 1; r < 32; r++)
                        if (mcnt[r] - reserved(r, av, aa, mv, ma) > 0) cand.push_back(r);
                    ma = (cand.size() == 0 || $urandom % 5 == 0) ? 5'd0
                         : 5'(cand[$urandom_range(cand.size() - 1, 0)]);
                    md = $urandom; mv = 1;
                end
                iv  = ($urandom % 3) != 0;
                rs  = 5'($urandom % 8);
                rt  = 5'($urandom % 8);
                dst = 5'($urandom % 8);
                wen = 1'($urandom % 2);
                drive(iv, rs, rt, wen, dst, av, aa, ad, mv, ma, md);

                es = iv && ((rs != 0 && mcnt[rs] > 0) || (rt != 0 && mcnt[rt] > 0) ||
                            (wen && dst != 0 && mcnt[dst] == 3));
                ga = av && (!mv || mprio == 0);
                gm = mv && !ga;
                ewa  = ga ? aa : (gm ? ma : 5'd0);
                ewd  = ga ? ad : (gm ? md : 32'd0);
                ewen = (ga || gm) && ewa != 0;
                #1;
                chk_all("rand", es, ga, gm, ewen, ewa, ewd);
                tick();

                if (iv && !es && wen && dst != 0) mcnt[dst]++;
                if (ewen && mcnt[ewa] > 0) mcnt[ewa]--;
                if (av && mv) mprio = ga ? 1 : 0;
                if (ga) av = 0;
                if (gm) mv = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-port scheduler and RAW scoreboard for the pipelined CPU's 31×32 register file. It merges two writeback requesters, the ALU pipe (A) and the load/memory pipe (M), onto the single register-file write port using round-robin arbitration. It also tracks in-flight destination registers and raises a stall to the decode stage on read-after-write hazards. It sits between the writeback stages and the register file, beside the decode/issue logic.

## Interface
- `DATA_W`, 32, write-data width
- `AW`, 5, register address width (2^AW registers, r0 hardwired zero)
- `CNT_W`, 2, width of each per-register in-flight counter
- `clk` input 1: rising edge updates all state
- `reset` input 1: reset, asynchronous, active-low
- `iss_valid` input 1: decode wants to issue an instruction this cycle
- `iss_rs`, `iss_rt` input AW: source registers of the issuing instruction
- `iss_wen` input 1: issuing instruction writes a register
- `iss_dst` input AW: destination register of the issuing instruction
- `stall` output 1: issue blocked this cycle (combinational)
- `a_valid`, `m_valid` input 1: writeback request from A or M
- `a_addr`, `m_addr` input AW: writeback destination register
- `a_data`, `m_data` input DATA_W: writeback data
- `a_ready`, `m_ready` output 1: request accepted this cycle (combinational)
- `rf_wen` output 1: register-file write enable
- `rf_waddr` output AW: register-file write address
- `rf_wdata` output DATA_W: register-file write data

## Operation
- Scoreboard: `cnt[r]` holds the number of issued-but-not-written writes to register r, for r = 1..2^AW−1. r0 has no counter and never reads as busy.
- `busy(r)` = (r ≠ 0) && `cnt[r]` ≠ 0.
- `stall` = `iss_valid` && (`busy(iss_rs)` || `busy(iss_rt)` || (`iss_wen` && `iss_dst` ≠ 0 && `cnt[iss_dst]` == 2^CNT_W−1)).
- Issue fires when `iss_valid` && !`stall`. If `iss_wen` && `iss_dst` ≠ 0, that register's counter gets +1.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the requester selected by `prio` is granted; `prio` is a 1-bit register, 0 selects A.
  - After any cycle with both requesters valid, `prio` points to the requester that was not granted. `prio` holds otherwise.
- Granted requester sees ready = 1. The loser sees ready = 0 and must hold its request stable.
- On grant, the write port is driven: `rf_waddr`/`rf_wdata` come from the winner, and `rf_wen` = (addr ≠ 0). With no grant, `rf_wen` = 0 and addr/data = 0.
- A granted writeback with addr ≠ 0 decrements that register's counter by 1.
- Issue increment and writeback decrement on the same register in the same cycle leave the counter unchanged.
- Writeback to a register whose counter is 0 is a protocol error. The counter stays at 0 (no underflow) and the write still proceeds.
- Write-port outputs are combinational within the cycle. The register file commits on the falling edge of `clk`, so data written in cycle N is readable in cycle N+1.
- The scoreboard does not forward data. It stalls until the write is granted.

## Timing
- Reset (asynchronous, `reset` = 0): all counters = 0 and `prio` = 0.
- During reset, `stall` = `iss_valid` && 0 = 0 and ready/`rf_wen` follow the combinational rules with counters zeroed. Requesters must not assert valid during reset.
- Latency: a request presented in cycle N is granted in N or N+1 under contention, never later. Round-robin bounds the wait to 1 cycle per conflict.
- A stall caused by a source register clears in the cycle the matching counter reaches 0. Issue then proceeds that cycle, provided the write was granted on an earlier edge.
- A grant in cycle N lowers `busy` from cycle N+1.
- Reset asserted mid-operation discards all in-flight tracking. Pipelines must be flushed in the same reset.

## Structure
- Shared package `cpu_pkg`: `AW`/`DATA_W` constants, `REG_ZERO` = 5'd0, and the requester ID encoding (`WB_A` = 0, `WB_M` = 1).
- One natural sub-module: `rr_arb2`, the 2-requester round-robin arbiter holding `prio`.
- The scoreboard counters and the write-port mux stay in the top module.

## Test plan
- Reset, then issue `iss_wen`=1 `iss_dst`=5. Next cycle issue with `iss_rs`=5 → `stall`=1. Then A writes r5 = 0xDEADBEEF → `rf_wen`=1 `rf_waddr`=5. The following cycle `stall`=0.
- A and M both valid in 4 consecutive cycles (re-presenting after each grant) → grants alternate A, M, A, M. Loser's ready = 0 and the loser's data never appears on `rf_wdata`.
- Issue to r7 three times without writeback (CNT_W=2) → fourth issue to r7 `stall`=1. One writeback to r7 → `stall`=0 on the next cycle.
- Same-cycle issue `iss_dst`=9 and A writeback to r9 with `cnt[9]`=1 → `cnt[9]` stays 1 and `busy(9)` stays 1.
- Writeback to r0 with data 0x12345678 → ready = 1, `rf_wen`=0, no counter change. Issue with `iss_rs`=0 never stalls.
- Assert `reset` low with `cnt[3]`=2 and `prio`=1 → immediately `cnt[3]`=0 and `prio`=0, and an issue reading r3 does not stall after reset releases.
